// File: rtl/imem_ctrl_pkg.sv
// Shared constants and state encoding for the
// instruction-memory boot controller.
package imem_ctrl_pkg;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 64;

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_LOAD   = 3'd1,
    S_VERIFY = 3'd2,
    S_RUN    = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

endpackage

// File: rtl/imem_csum_acc.sv
// XOR checksum accumulator with
// synchronous clear and enable.
module imem_csum_acc #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (en) begin
      q <= q ^ d;
    end
  end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot loader, checksum verifier and fetch/debug
// arbiter for the single-port instruction memory.
module imem_boot_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int AW    = imem_ctrl_pkg::AW,
  parameter int DW    = imem_ctrl_pkg::DW,
  parameter int DEPTH = imem_ctrl_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  input  logic [DW-1:0] ld_checksum,
  output logic          ld_ready,
  input  logic          boot_go,
  input  logic [AW-1:0] pc_a,
  output logic [DW-1:0] cpu_instr,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_gnt,
  output logic [DW-1:0] dbg_data,
  output logic [AW-1:0] mem_a,
  output logic          mem_we,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic [2:0]    state,
  output logic          load_err
);

  state_t st, st_nx;

  logic [AW:0]   wr_ptr, rd_ptr, n;
  logic [DW-1:0] exp_cs, wcs, rcs, instr_q;
  logic          gnt_q;
  logic          beat, full, done_ld;
  logic          rd_en, cmp_done, pass, do_clr;

  assign state    = st;
  assign ld_ready = (st == S_BOOT) || (st == S_LOAD);
  assign beat     = ld_valid && ld_ready;
  assign full     = wr_ptr == (AW+1)'(DEPTH-1);
  assign done_ld  = beat && (ld_last || full);
  assign rd_en    = (st == S_VERIFY) && (rd_ptr != n);
  assign cmp_done = (st == S_VERIFY) && (rd_ptr == n);
  assign pass     = (rcs == wcs) && (rcs == exp_cs);
  assign do_clr   = (st == S_ERROR) && boot_go;
  assign load_err = st == S_ERROR;
  assign dbg_gnt  = (st == S_RUN) && dbg_req && !gnt_q;
  assign mem_we   = beat;
  assign mem_wd   = beat ? ld_data : '0;

  imem_csum_acc #(.DW(DW)) u_wcs (
    .clk   (clk),
    .reset (reset),
    .clr   (do_clr),
    .en    (beat),
    .d     (ld_data),
    .q     (wcs)
  );

  imem_csum_acc #(.DW(DW)) u_rcs (
    .clk   (clk),
    .reset (reset),
    .clr   (do_clr),
    .en    (rd_en),
    .d     (mem_rd),
    .q     (rcs)
  );

  always_comb begin
    st_nx     = st;
    mem_a     = '0;
    cpu_stall = 1'b1;
    cpu_instr = '0;
    unique case (st)
      S_BOOT: begin
        mem_a = wr_ptr[AW-1:0];
        if (beat) begin
          st_nx = done_ld ? S_VERIFY : S_LOAD;
        end else if (boot_go) begin
          st_nx = S_RUN;
        end
      end
      S_LOAD: begin
        mem_a = wr_ptr[AW-1:0];
        if (done_ld) st_nx = S_VERIFY;
      end
      S_VERIFY: begin
        mem_a = rd_ptr[AW-1:0];
        if (cmp_done) st_nx = pass ? S_RUN : S_ERROR;
      end
      S_RUN: begin
        cpu_stall = dbg_gnt;
        mem_a     = dbg_gnt ? dbg_addr : pc_a;
        cpu_instr = dbg_gnt ? instr_q : mem_rd;
      end
      S_ERROR: begin
        if (boot_go) st_nx = S_BOOT;
      end
      default: st_nx = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= S_BOOT;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      n        <= '0;
      exp_cs   <= '0;
      instr_q  <= '0;
      gnt_q    <= 1'b0;
      dbg_data <= '0;
    end else begin
      st    <= st_nx;
      gnt_q <= dbg_gnt;
      if (beat) wr_ptr <= wr_ptr + 1'b1;
      // A full buffer without ld_last checks only against itself
      if (done_ld) begin
        n      <= wr_ptr + 1'b1;
        exp_cs <= ld_last ? ld_checksum : (wcs ^ ld_data);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end else if (cmp_done) begin
        rd_ptr <= '0;
      end
      if (do_clr) begin
        wr_ptr <= '0;
        n      <= '0;
      end
      if (st == S_RUN && !dbg_gnt) instr_q <= mem_rd;
      if (dbg_gnt) dbg_data <= mem_rd;
    end
  end

endmodule
